// File: rtl/rv_writeback_stage.sv
// rtl/rv_writeback_stage.sv - writeback stage: load align, EX/MEM arbitration, EX FIFO, register write port (optional WB_RETIRE_CNT_EN)
module rv_writeback_stage #(
    parameter int XLEN          = 32,
    parameter int EX_FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [4:0]      ex_rd,
    input  logic [XLEN-1:0] ex_result,
    input  logic            mem_valid,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic [1:0]      mem_addr_lo,
    input  logic [2:0]      mem_funct3,
    output logic            reg_we,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] rd_val,
    output logic            load_err,
    output logic [31:0]     retire_cnt
);

    localparam int AW = (EX_FIFO_DEPTH > 1) ? $clog2(EX_FIFO_DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(EX_FIFO_DEPTH);

    logic [4:0]      fifo_rd  [EX_FIFO_DEPTH];
    logic [XLEN-1:0] fifo_val [EX_FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;

    logic            fifo_empty;
    logic            ex_accept;
    logic [7:0]      lane_byte;
    logic [15:0]     lane_half;
    logic            load_ok;
    logic [XLEN-1:0] load_val;

    logic            take;
    logic [4:0]      take_rd;
    logic [XLEN-1:0] take_val;
    logic            take_err;
    logic            push, pop;

    // Full is judged on the registered count only, so a same-cycle pop never reopens the port.
    assign ex_ready   = (count != FULL_CNT);
    assign fifo_empty = (count == '0);
    assign ex_accept  = ex_valid && ex_ready;

    // Extract the addressed byte/halfword, extend it, and flag illegal or misaligned loads.
    always_comb begin
        lane_byte = 8'h00;
        lane_half = mem_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_ok   = 1'b0;
        load_val  = mem_rdata;
        case (mem_addr_lo)
            2'd0:    lane_byte = mem_rdata[7:0];
            2'd1:    lane_byte = mem_rdata[15:8];
            2'd2:    lane_byte = mem_rdata[23:16];
            default: lane_byte = mem_rdata[31:24];
        endcase
        case (mem_funct3)
            3'b000, 3'b100: begin
                load_ok  = 1'b1;
                load_val = {{(XLEN-8){lane_byte[7] & ~mem_funct3[2]}}, lane_byte};
            end
            3'b001, 3'b101: begin
                load_ok  = ~mem_addr_lo[0];
                load_val = {{(XLEN-16){lane_half[15] & ~mem_funct3[2]}}, lane_half};
            end
            3'b010: begin
                load_ok  = (mem_addr_lo == 2'd0);
                load_val = mem_rdata;
            end
            default: load_ok = 1'b0;
        endcase
    end

    // Pick the source for the output register: MEM first, then the FIFO head, then a bypassed EX beat.
    always_comb begin
        take     = 1'b0;
        take_rd  = mem_rd;
        take_val = load_val;
        take_err = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        if (mem_valid) begin
            take     = load_ok;
            take_err = ~load_ok;
            push     = ex_accept;
        end else if (!fifo_empty) begin
            take     = 1'b1;
            take_rd  = fifo_rd[rd_ptr];
            take_val = fifo_val[rd_ptr];
            pop      = 1'b1;
            push     = ex_accept;
        end else if (ex_accept) begin
            take     = 1'b1;
            take_rd  = ex_rd;
            take_val = ex_result;
        end
    end

    // EX buffer storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr]  <= ex_rd;
            fifo_val[wr_ptr] <= ex_result;
        end
    end

    // EX buffer pointers and occupancy; pointers wrap naturally on the power-of-two depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Register write port; x0 writes are suppressed and zeroed but rd/rd_val otherwise hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_we   <= 1'b0;
            rd       <= '0;
            rd_val   <= '0;
            load_err <= 1'b0;
        end else begin
            load_err <= take_err;
            reg_we   <= take && (take_rd != 5'd0);
            if (take) begin
                rd     <= take_rd;
                rd_val <= (take_rd == 5'd0) ? '0 : take_val;
            end
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_q;

    // Count every selected writeback, x0 included, in step with the write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_q <= '0;
        end else if (take) begin
            retire_q <= retire_q + 32'd1;
        end
    end

    assign retire_cnt = retire_q;
`else
    assign retire_cnt = 32'd0;
`endif

endmodule
